// File: rtl/idft2_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : idft2_stream                                                     |
// | Purpose  : Streaming 2-point inverse DFT. Takes sample pair (A, B) and      |
// |            emits (A+B)/2 then (A-B)/2 per component. When the macro         |
// |            IDFT2_ROUND_EN is defined, results round half up.                |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module idft2_stream #(
  parameter int WORD_SZ = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [WORD_SZ-1:0] i_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [WORD_SZ-1:0] o_data,
  output logic               o_last
);

  localparam int c_half = WORD_SZ / 2;

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_OUT0 = 2'd2,
    S_OUT1 = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WORD_SZ-1:0] r_a;
  logic [WORD_SZ-1:0] r_x1;
  logic [WORD_SZ-1:0] w_x0;
  logic [WORD_SZ-1:0] w_x1;
  logic               w_accept;
  logic               w_out_hs;

  assign o_ready  = ((r_state == S_A) || (r_state == S_B)) && !i_rst;
  assign w_accept = i_valid && o_ready;
  assign w_out_hs = o_valid && i_ready;

  // Each component: sign-extend one bit, add/subtract, optional +1, then >>>1.
  // Keeping bits [c_half:1] of the widened result is the shift plus truncation.
  for (genvar k = 0; k < 2; k++) begin : g_comp
    logic [c_half:0] w_a_ext;
    logic [c_half:0] w_b_ext;
    logic [c_half:0] w_sum;
    logic [c_half:0] w_dif;
    logic [c_half:0] w_sum_adj;
    logic [c_half:0] w_dif_adj;
    logic            w_unused_lsb;

    assign w_a_ext = {r_a[k*c_half + c_half - 1], r_a[k*c_half +: c_half]};
    assign w_b_ext = {i_data[k*c_half + c_half - 1], i_data[k*c_half +: c_half]};
    assign w_sum   = w_a_ext + w_b_ext;
    assign w_dif   = w_a_ext - w_b_ext;

`ifdef IDFT2_ROUND_EN
    assign w_sum_adj = w_sum + {{c_half{1'b0}}, 1'b1};
    assign w_dif_adj = w_dif + {{c_half{1'b0}}, 1'b1};
`else
    assign w_sum_adj = w_sum;
    assign w_dif_adj = w_dif;
`endif

    assign w_x0[k*c_half +: c_half] = w_sum_adj[c_half:1];
    assign w_x1[k*c_half +: c_half] = w_dif_adj[c_half:1];
    assign w_unused_lsb             = w_sum_adj[0] ^ w_dif_adj[0];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_A;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_A:     if (w_accept) w_state_nxt = S_B;
      S_B:     if (w_accept) w_state_nxt = S_OUT0;
      S_OUT0:  if (w_out_hs) w_state_nxt = S_OUT1;
      S_OUT1:  if (w_out_hs) w_state_nxt = S_A;
      default: w_state_nxt = S_A;
    endcase
  end

  // Output registers only move on a handshake, so o_data is stable under stall.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_a     <= '0;
      r_x1    <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
    end else begin
      case (r_state)
        S_A: begin
          if (w_accept) r_a <= i_data;
        end
        S_B: begin
          if (w_accept) begin
            o_data  <= w_x0;
            r_x1    <= w_x1;
            o_valid <= 1'b1;
            o_last  <= 1'b0;
          end
        end
        S_OUT0: begin
          if (w_out_hs) begin
            o_data <= r_x1;
            o_last <= 1'b1;
          end
        end
        S_OUT1: begin
          if (w_out_hs) begin
            o_valid <= 1'b0;
            o_last  <= 1'b0;
          end
        end
        default: begin
          o_valid <= 1'b0;
          o_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
